// File: rtl/dma_buff_addr_sequencer.sv
// Ring-buffer address sequencer: primes the DMA address FIFO, then pushes one address per frame-done rise
// (rise -> wen in 2 cycles, fifo_full_i stalls pushes, excess rises count as drops); watchdog under DMA_SEQ_WATCHDOG_EN.
module dma_buff_addr_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned NUM_BUFFERS    = 4,
  parameter int unsigned PREFETCH_DEPTH = 2,
  parameter int unsigned DROP_CNT_WIDTH = 16,
  parameter logic [23:0] WDT_LIMIT      = 24'd16_000_000
) (
  input  logic                      sys_clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic [ADDR_WIDTH-1:0]     base_addr_i,
  input  logic [ADDR_WIDTH-1:0]     frame_size_i,
  input  logic [2:0]                num_buff_i,
  input  logic                      interrupt_i,
  input  logic                      fifo_full_i,
  output logic                      buff_addr_fifo_wen_o,
  output logic [ADDR_WIDTH-1:0]     buff_addr_fifo_data_o,
  output logic [ADDR_WIDTH-1:0]     display_buff_addr_o,
  output logic [DROP_CNT_WIDTH-1:0] frame_drop_count_o,
  output logic                      busy_o,
  output logic                      timeout_o
);
  localparam int unsigned   PW       = $clog2(PREFETCH_DEPTH + 1);
  localparam logic [PW-1:0] PD       = PW'(PREFETCH_DEPTH);
  localparam logic [PW-1:0] PD_M1    = PW'(PREFETCH_DEPTH - 1);
  localparam logic [2:0]    MAX_LAST = 3'(NUM_BUFFERS - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  state_t state, state_nxt;

  logic                  intr_dly;
  logic [ADDR_WIDTH-1:0] base_q, stride_q, wr_addr, done_addr;
  logic [2:0]            ring_last, ring_last_sel, wr_idx, done_idx;
  logic [PW-1:0]         pending, prime_cnt;
  logic                  busy, start, rise, push, pend_inc, drop;

  assign ring_last_sel = (num_buff_i > MAX_LAST) ? MAX_LAST : num_buff_i;

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable_i) state_nxt = PRIME;
      PRIME:   if (!enable_i) state_nxt = IDLE;
               else if (push && prime_cnt == PD_M1) state_nxt = RUN;
      RUN:     if (!enable_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    start    = (state == IDLE) && enable_i;
    rise     = interrupt_i && !intr_dly && busy && enable_i;
    push     = busy && enable_i && !fifo_full_i &&
               ((state == PRIME) || ((state == RUN) && (pending != '0)));
    pend_inc = rise && (state == RUN);
    // A rise that finds the pending window full is lost unless a push frees a slot this cycle.
    drop     = pend_inc && (pending == PD) && !push;
  end

  assign busy_o = busy;

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      intr_dly              <= 1'b0;
      buff_addr_fifo_wen_o  <= 1'b0;
      buff_addr_fifo_data_o <= '0;
      display_buff_addr_o   <= '0;
      frame_drop_count_o    <= '0;
      base_q                <= '0;
      stride_q              <= '0;
      ring_last             <= '0;
      wr_idx                <= '0;
      wr_addr               <= '0;
      done_idx              <= '0;
      done_addr             <= '0;
      pending               <= '0;
      prime_cnt             <= '0;
    end else begin
      intr_dly             <= interrupt_i;
      buff_addr_fifo_wen_o <= push;
      if (start) begin
        base_q    <= base_addr_i;
        stride_q  <= frame_size_i;
        ring_last <= ring_last_sel;
        wr_idx    <= '0;
        wr_addr   <= base_addr_i;
        done_idx  <= '0;
        done_addr <= base_addr_i;
        prime_cnt <= '0;
      end
      if (push) begin
        buff_addr_fifo_data_o <= wr_addr;
        if (wr_idx == ring_last) begin
          wr_idx  <= '0;
          wr_addr <= base_q;
        end else begin
          wr_idx  <= wr_idx + 3'd1;
          wr_addr <= wr_addr + stride_q;
        end
        if (state == PRIME) prime_cnt <= prime_cnt + PW'(1);
      end
      if (rise) begin
        display_buff_addr_o <= done_addr;
        if (done_idx == ring_last) begin
          done_idx  <= '0;
          done_addr <= base_q;
        end else begin
          done_idx  <= done_idx + 3'd1;
          done_addr <= done_addr + stride_q;
        end
      end
      if (state != RUN || !enable_i)       pending <= '0;
      else if (pend_inc && !drop && !push) pending <= pending + PW'(1);
      else if (push && !pend_inc)          pending <= pending - PW'(1);
      if (drop && frame_drop_count_o != '1)
        frame_drop_count_o <= frame_drop_count_o + DROP_CNT_WIDTH'(1);
    end
  end

`ifdef DMA_SEQ_WATCHDOG_EN
  logic [23:0] wdt_cnt;
  logic        timeout_q;

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdt_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state != RUN || state_nxt != RUN || rise) wdt_cnt <= '0;
      else if (wdt_cnt != WDT_LIMIT)                wdt_cnt <= wdt_cnt + 24'd1;
      if (state_nxt == IDLE)                                 timeout_q <= 1'b0;
      else if (state == RUN && wdt_cnt == WDT_LIMIT)         timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0 & (|WDT_LIMIT);
`endif

endmodule

// File: doc/dma_buff_addr_sequencer.md
Name: dma_buff_addr_sequencer

Overview:
- Controller feeding frame-buffer start addresses to the DMA engine's buffer-address FIFO.
- Rotates through a runtime-selectable ring of equally sized DDR frame buffers, with base + idx*frame_size.
- Primes the FIFO on enable, then pushes one new address per DMA frame-done interrupt.
- Publishes the most recently completed buffer address to the display/read side, and counts frames dropped due to backpressure.

Parameters:
- ADDR_WIDTH, 32, width of buffer addresses and frame size.
- NUM_BUFFERS, 4, maximum ring depth (legal 1..8).
- PREFETCH_DEPTH, 2, addresses pushed during priming; also the pending-push limit (legal 1..4).
- DROP_CNT_WIDTH, 16, width of the drop counter.
- WDT_LIMIT, 24'd16_000_000, watchdog cycle limit (used only with the optional feature).

Ports:
- sys_clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  sequencer run enable (level).
- base_addr_i  in  ADDR_WIDTH  address of buffer 0.
- frame_size_i  in  ADDR_WIDTH  byte stride between buffers.
- num_buff_i  in  3  ring depth minus 1 (0 means 1 buffer).
- interrupt_i  in  1  DMA frame-done, level.
- fifo_full_i  in  1  buffer-address FIFO full.
- buff_addr_fifo_wen_o  out  1  FIFO write strobe, one-cycle pulse per address.
- buff_addr_fifo_data_o  out  ADDR_WIDTH  address written.
- display_buff_addr_o  out  ADDR_WIDTH  last completed buffer address.
- frame_drop_count_o  out  DROP_CNT_WIDTH  saturating dropped-frame count.
- busy_o  out  1  high when state is not IDLE.
- timeout_o  out  1  watchdog flag (optional feature only).

Behaviour:
- Reset: all outputs 0, state IDLE, all pointers and counters 0, interrupt delay register 0.
- Reset is asynchronous: asserting rst_i mid-operation forces IDLE immediately and abandons any pending pushes.
- Rise detect: rise = interrupt_i & ~interrupt_dly. The delay register tracks interrupt_i every cycle in all states. Rises are ignored in IDLE.
- IDLE -> PRIME when enable_i = 1. On this transition the block latches:
  - base_addr_i and frame_size_i;
  - ring size = min(num_buff_i + 1, NUM_BUFFERS).
  - Config inputs are ignored while busy.
- Two ring pointers exist, each holding (idx, addr) and both reset to (0, base):
  - wr_ptr advances on every push;
  - done_ptr advances on every rise.
- Pointer advance: addr += frame_size and idx += 1. When idx = ring size - 1, both wrap to (0, base). No multiplier is used. Address arithmetic is modulo 2^ADDR_WIDTH.
- PRIME:
  - In each cycle with fifo_full_i = 0, push wr_ptr.addr (wen = 1, data = addr) and advance wr_ptr.
  - After PREFETCH_DEPTH pushes -> RUN. fifo_full_i stalls priming without any loss.
- Each rise, in PRIME or RUN:
  - display_buff_addr_o <= done_ptr.addr, and done_ptr advances;
  - pending += 1, in RUN only.
- RUN: a cycle with pending > 0 and fifo_full_i = 0 pushes wr_ptr.addr and decrements pending.
- Simultaneous rise and push leaves pending unchanged.
- If a rise occurs with pending = PREFETCH_DEPTH, pending stays the same and frame_drop_count_o increments, saturating at all-ones.
- Latency: rise in cycle C (fifo not full) -> pending = 1 in C+1 -> wen_o high in cycle C+2.
- wen_o and data_o are registered. wen_o is never high in two cycles unless both pushes are legitimate. fifo_full_i is sampled in the cycle before the wen cycle.
- enable_i = 0 in PRIME or RUN -> IDLE next cycle:
  - pending is cleared;
  - display_buff_addr_o and frame_drop_count_o are held;
  - frame_drop_count_o clears only on reset.
- Ring size 1: every push and every display update uses base.

Optional Feature:
- DMA_SEQ_WATCHDOG_EN defined:
  - A 24-bit cycle counter runs in RUN and clears on each rise and on leaving RUN.
  - On reaching WDT_LIMIT, timeout_o is set sticky; it is cleared only by reset or by entering IDLE.
  - The counter holds at the limit.
- Undefined: no counter is instantiated and timeout_o is tied to 0.

Test Plan:
- Config base = 0x8000_0000, frame_size = 0x0020_0000, num_buff = 3, enable = 1, full = 0 -> wen pulses with 0x8000_0000, 0x8020_0000; busy_o = 1; state RUN.
- In RUN, 6 interrupt rises spaced 100 cycles -> pushes 0x8040_0000, 0x8060_0000, 0x8000_0000, 0x8020_0000, 0x8040_0000, 0x8060_0000; display_buff_addr_o = 0x8000_0000, 0x8020_0000, ... 0x8020_0000.
- Hold fifo_full_i = 1 and send 4 rises -> pending saturates at 2, frame_drop_count_o = 2; release full -> exactly 2 wen pulses.
- Rise in cycle C with full = 0 -> wen_o in C+2. A rise coinciding with a push cycle -> pending unchanged, no drop.
- num_buff = 0 with 3 rises -> all data_o and display values = base. num_buff = 7 with NUM_BUFFERS = 4 -> wraps after 4.
- Assert rst_i while pending = 2 -> all outputs 0 with no clock edge needed. With DMA_SEQ_WATCHDOG_EN and WDT_LIMIT = 50, no rise for 50 cycles -> timeout_o = 1; deassert enable -> timeout_o = 0.
